// File: rtl/mux_scan_sequencer_if.sv
// Bus bundle between the scan sequencer, the ADC front end and the sample consumer.
// The slave modport is the sequencer's view; the master is the environment's view.
interface mux_scan_sequencer_if #(
  parameter int unsigned ADC_W = 12
);
  logic             start;
  logic             continuous;
  logic             stop;
  logic [4:0]       A_in;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;
  logic             sample_valid;
  logic [ADC_W-1:0] sample_data;
  logic [4:0]       sample_ch;
  logic             sample_err;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport slave (
    input  start, continuous, stop, adc_done, adc_data,
    output A_in, adc_start, sample_valid, sample_data, sample_ch, sample_err,
           frame_start, frame_done, busy
  );

  modport master (
    output start, continuous, stop, adc_done, adc_data,
    input  A_in, adc_start, sample_valid, sample_data, sample_ch, sample_err,
           frame_start, frame_done, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the mux channel index, waits for settling, triggers one ADC conversion per
// channel and emits a tagged sample; single-frame or continuous scanning.
module mux_scan_sequencer #(
  parameter int unsigned NUM_CH        = 32,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ADC_W         = 12,
  parameter int unsigned TIMEOUT       = 64
) (
  input logic                clock,
  input logic                reset,
  mux_scan_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSettle, StConvert, StWait, StSample} state_e;

  localparam logic [4:0] LastCh     = 5'(NUM_CH - 1);
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] WaitLast   = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] settle_cnt_q;
  logic [7:0] wait_cnt_q;
  logic       stop_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      settle_cnt_q     <= '0;
      wait_cnt_q       <= '0;
      stop_q           <= 1'b0;
      bus.A_in         <= '0;
      bus.adc_start    <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_data  <= '0;
      bus.sample_ch    <= '0;
      bus.sample_err   <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      bus.adc_start    <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.frame_done   <= 1'b0;

      if (state_q != StIdle && bus.stop) begin
        stop_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q         <= StSettle;
            bus.A_in        <= '0;
            settle_cnt_q    <= SettleLoad;
            bus.frame_start <= 1'b1;
            bus.busy        <= 1'b1;
          end
        end
        StSettle: begin
          if (settle_cnt_q == 8'd0) begin
            state_q       <= StConvert;
            bus.adc_start <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end
        StConvert: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (bus.adc_done || wait_cnt_q == WaitLast) begin
            state_q          <= StSample;
            bus.sample_valid <= 1'b1;
            bus.sample_ch    <= bus.A_in;
            bus.frame_done   <= (bus.A_in == LastCh);
            bus.sample_data  <= bus.adc_done ? bus.adc_data : '0;
            bus.sample_err   <= ~bus.adc_done;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StSample: begin
          if (bus.A_in != LastCh) begin
            state_q      <= StSettle;
            bus.A_in     <= bus.A_in + 5'd1;
            settle_cnt_q <= SettleLoad;
          end else if (bus.continuous && !stop_q && !bus.stop) begin
            state_q         <= StSettle;
            bus.A_in        <= '0;
            settle_cnt_q    <= SettleLoad;
            bus.frame_start <= 1'b1;
          end else begin
            state_q  <= StIdle;
            bus.A_in <= '0;
            bus.busy <= 1'b0;
            stop_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: a behavioural scan-order model queues the
// expected samples, an independent monitor checks every strobe, pulse and timing gap.
module tb_mux_scan_sequencer;
  localparam int NUM_CH  = 32;
  localparam int SETTLE  = 16;
  localparam int ADC_W   = 12;
  localparam int TIMEOUT = 64;

  typedef struct {
    int ch;
    int data;
    int err;
    int fd;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.ADC_W(ADC_W)) bus ();

  mux_scan_sequencer #(
    .NUM_CH       (NUM_CH),
    .SETTLE_CYCLES(SETTLE),
    .ADC_W        (ADC_W),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  exp_t   exp_q[$];
  int     fs_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     tab[NUM_CH];
  int     silent_ch = -1;
  bit     spur_en = 1'b0;
  bit     inject_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected scan order: channels 0..n-1; channel period = settle + convert + k wait + sample.
  task automatic plan_frame(input bit from_idle, input int n_ch);
    exp_t e;
    for (int c = 0; c < n_ch; c++) begin
      e.ch   = c;
      e.err  = (c == silent_ch) ? 1 : 0;
      e.data = e.err ? 0 : tab[c];
      e.fd   = (c == NUM_CH - 1) ? 1 : 0;
      e.gap  = (c == 0 && from_idle) ? 0 : SETTLE + 2 + (e.err ? TIMEOUT : 1);
      exp_q.push_back(e);
    end
    fs_q.push_back(from_idle ? 0 : 1);
  endtask

  task automatic fill_tab(input bit ramp);
    for (int c = 0; c < NUM_CH; c++) tab[c] = ramp ? 'h100 + c : int'($urandom_range(4095, 0));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || fs_q.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending_samples"}, exp_q.size(), 0);
    chk({name, "_pending_frames"}, fs_q.size(), 0);
    exp_q.delete();
    fs_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_idle_busy"}, bus.busy, 0);
    chk({name, "_idle_a_in"}, bus.A_in, 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_a_in"}, bus.A_in, 0);
    chk({name, "_adc_start"}, bus.adc_start, 0);
    chk({name, "_sample_valid"}, bus.sample_valid, 0);
    chk({name, "_sample_data"}, bus.sample_data, 0);
    chk({name, "_sample_ch"}, bus.sample_ch, 0);
    chk({name, "_sample_err"}, bus.sample_err, 0);
    chk({name, "_frame_start"}, bus.frame_start, 0);
    chk({name, "_frame_done"}, bus.frame_done, 0);
    chk({name, "_busy"}, bus.busy, 0);
  endtask

  // ADC model: answers one cycle after adc_start unless the channel is silenced.
  bit         pend = 1'b0;
  int         pend_data = 0;
  logic [4:0] a_prev = '0;
  always @(posedge clk) begin
    #1;
    bus.adc_done = pend;
    bus.adc_data = ADC_W'(pend_data);
    pend = 1'b0;
    if (bus.adc_start && int'(bus.A_in) != silent_ch) begin
      pend      = 1'b1;
      pend_data = tab[bus.A_in];
    end
    if (spur_en && !bus.adc_done && (bus.sample_valid || bus.frame_start || bus.A_in != a_prev)
        && $urandom_range(1, 0) == 1) begin
      bus.adc_done = 1'b1;
      bus.adc_data = ADC_W'($urandom);
    end
    if (inject_done) begin
      bus.adc_done = 1'b1;
      bus.adc_data = ADC_W'($urandom);
      inject_done  = 1'b0;
    end
    a_prev = bus.A_in;
  end

  // Monitor
  exp_t       mon_e;
  int         mon_g;
  longint     last_strobe = 0;
  int         stable = 0;
  logic [4:0] prev_a = '0;
  logic [4:0] conv_ch = '0;
  always @(negedge clk) begin
    if (bus.A_in != prev_a) stable = 0;
    else stable++;
    prev_a = bus.A_in;

    if (bus.adc_start) begin
      if (bus.A_in != 0) chk("settle_len", stable, SETTLE);
      conv_ch = bus.A_in;
    end
    if (bus.sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual_ch=%0d required=no_strobe", bus.sample_ch);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sample_ch", bus.sample_ch, mon_e.ch);
        chk("sample_data", bus.sample_data, mon_e.data);
        chk("sample_err", bus.sample_err, mon_e.err);
        chk("frame_done", bus.frame_done, mon_e.fd);
        chk("a_in_held_through_conv", bus.A_in, conv_ch);
        if (mon_e.gap != 0) chk("strobe_gap", cyc - last_strobe, mon_e.gap);
      end
      last_strobe = cyc;
    end else if (bus.frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_strobe actual=1 required=0");
    end
    if (bus.frame_start) begin
      if (fs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_start actual=1 required=0");
      end else begin
        mon_g = fs_q.pop_front();
        chk("frame_start_a_in", bus.A_in, 0);
        if (mon_g != 0) chk("frame_start_gap", cyc - last_strobe, mon_g);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  done;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.stop       = 1'b0;
    bus.adc_done   = 1'b0;
    bus.adc_data   = '0;
    fill_tab(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Single frame, ramp data.
    plan_frame(1'b1, NUM_CH);
    pulse_start();
    wait_drain("single", 800);

    // Continuous, stop in the middle of the third frame.
    fill_tab(1'b0);
    bus.continuous = 1'b1;
    for (int f = 0; f < 3; f++) plan_frame(f == 0, NUM_CH);
    pulse_start();
    repeat ($urandom_range(1750, 1250)) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
    wait_drain("continuous", 1000);
    bus.continuous = 1'b0;

    // Silent channel 5 times out.
    fill_tab(1'b0);
    silent_ch = 5;
    plan_frame(1'b1, NUM_CH);
    pulse_start();
    wait_drain("timeout", 900);
    silent_ch = -1;

    // Spurious adc_done and start pulses while busy.
    fill_tab(1'b1);
    spur_en = 1'b1;
    plan_frame(1'b1, NUM_CH);
    pulse_start();
    n = 0;
    done = 1'b0;
    while (!done && n < 1000) begin
      @(posedge clk);
      #1;
      done = bus.frame_done;
      bus.start = done ? 1'b0 : ($urandom_range(3, 0) == 0);
      n++;
    end
    bus.start = 1'b0;
    spur_en = 1'b0;
    wait_drain("spurious", 200);

    // Reset during WAIT of channel 10, then a late adc_done.
    fill_tab(1'b0);
    silent_ch = 10;
    plan_frame(1'b1, 10);
    pulse_start();
    n = 0;
    done = 1'b0;
    while (!done && n < 1000) begin
      @(posedge clk);
      #1;
      done = bus.adc_start && bus.A_in == 5'd10;
      n++;
    end
    chk("reach_ch10_conversion", done, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midreset");
    rst = 1'b0;
    inject_done = 1'b1;
    silent_ch = -1;
    wait_drain("after_reset", 100);
    repeat (60) @(posedge clk);
    #1 chk("after_reset_still_idle", bus.busy, 0);
    plan_frame(1'b1, NUM_CH);
    pulse_start();
    wait_drain("restart", 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
